// File: rtl/fetch_req_ctrl_pkg.sv
// Shared types and constants for the pre-IF fetch request controller.
// Field order of the IF-bound bus lives here so producer and consumer agree.
package fetch_req_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam int          TO_FS_BUS_WD     = 35;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic tlb_miss;
        logic tlb_invalid;
        logic pc_adel;
    } fetch_exc_t;

    // {tlb_miss, tlb_invalid, pc_adel, pc}, MSB first.
    typedef struct packed {
        fetch_exc_t  exc;
        logic [31:0] pc;
    } to_fs_bus_t;

endpackage

// File: rtl/fetch_req_ctrl_if.sv
// Handshake bundle between the fetch request controller, the ITLB/icache,
// the branch predictor and the IF stage.
interface fetch_req_ctrl_if;
    import fetch_req_ctrl_pkg::*;

    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    bp_taken;
    logic [31:0]             bp_target;
    logic                    tlb_miss;
    logic                    tlb_invalid;
    logic                    icache_req;
    logic [31:0]             icache_addr;
    logic                    icache_addr_ok;
    logic                    icache_data_ok;
    logic                    fetch_data_ok;
    logic                    fs_allowin;
    logic                    prefs_to_fs_valid;
    logic [TO_FS_BUS_WD-1:0] prefs_to_fs_bus;
    fetch_state_e            dbg_state;

    // icache: request transfers when icache_req & icache_addr_ok in the same cycle.
    // IF: a PC transfers when prefs_to_fs_valid & fs_allowin in the same cycle.
    modport master (
        input  redirect_valid, redirect_pc, bp_taken, bp_target,
        input  tlb_miss, tlb_invalid, icache_addr_ok, icache_data_ok, fs_allowin,
        output icache_req, icache_addr, fetch_data_ok,
        output prefs_to_fs_valid, prefs_to_fs_bus, dbg_state
    );

    modport slave (
        output redirect_valid, redirect_pc, bp_taken, bp_target,
        output tlb_miss, tlb_invalid, icache_addr_ok, icache_data_ok, fs_allowin,
        input  icache_req, icache_addr, fetch_data_ok,
        input  prefs_to_fs_valid, prefs_to_fs_bus, dbg_state
    );

endinterface

// File: rtl/fetch_req_ctrl.sv
// Pre-IF fetch request controller: owns the fetch PC, issues icache requests and
// drops responses made stale by redirects. Define FETCH_BPRED_EN to follow the predictor.
module fetch_req_ctrl
    import fetch_req_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_req_ctrl_if.master  f
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, next_pc;
    logic [1:0]   outst_cnt_q, outst_cnt_d;
    logic [1:0]   cancel_cnt_q, cancel_cnt_d;
    fetch_exc_t   held_exc_q, held_exc_d;
    fetch_exc_t   cur_exc;
    logic         exc, req, accepted, to_fs_valid, addr_hs;
    to_fs_bus_t   bus;

`ifndef FETCH_BPRED_EN
    logic unused_bp;
    assign unused_bp = ^{f.bp_taken, f.bp_target};
`endif

    always_comb begin
        cur_exc.tlb_miss    = f.tlb_miss;
        cur_exc.tlb_invalid = f.tlb_invalid;
        cur_exc.pc_adel     = (pc_q[1:0] != 2'b00);
        exc                 = |cur_exc;

`ifdef FETCH_BPRED_EN
        next_pc = f.bp_taken ? f.bp_target : pc_q + 32'd4;
`else
        next_pc = pc_q + 32'd4;
`endif

        req         = 1'b0;
        accepted    = 1'b0;
        to_fs_valid = 1'b0;
        bus         = {cur_exc, pc_q};
        if (state_q == ST_REQ) begin
            req         = !exc && !f.redirect_valid && (outst_cnt_q < MAX_CNT);
            // An exception PC goes to IF without touching memory.
            accepted    = (req && f.icache_addr_ok) || (exc && !f.redirect_valid);
            to_fs_valid = accepted && f.fs_allowin;
        end else begin
            to_fs_valid = !f.redirect_valid;
            bus         = {held_exc_q, pc_q};
        end
        addr_hs = req && f.icache_addr_ok;

        state_d    = state_q;
        pc_d       = pc_q;
        held_exc_d = held_exc_q;
        if (f.redirect_valid) begin
            state_d = ST_REQ;
            pc_d    = f.redirect_pc;
        end else if (state_q == ST_REQ) begin
            if (accepted && f.fs_allowin) begin
                pc_d = next_pc;
            end else if (accepted) begin
                state_d    = ST_HOLD;
                held_exc_d = cur_exc;
            end
        end else if (f.fs_allowin) begin
            state_d = ST_REQ;
            pc_d    = next_pc;
        end

        outst_cnt_d = outst_cnt_q + {1'b0, addr_hs} - {1'b0, f.icache_data_ok};

        // Everything still in flight at a redirect belongs to the flushed path.
        if (f.redirect_valid) begin
            cancel_cnt_d = outst_cnt_q - {1'b0, f.icache_data_ok};
        end else if (f.icache_data_ok && (cancel_cnt_q != 2'd0)) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
        end else begin
            cancel_cnt_d = cancel_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            outst_cnt_q  <= 2'd0;
            cancel_cnt_q <= 2'd0;
            held_exc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            outst_cnt_q  <= outst_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
            held_exc_q   <= held_exc_d;
        end
    end

    assign f.icache_req        = req & ~reset;
    assign f.icache_addr       = reset ? 32'd0 : pc_q;
    assign f.fetch_data_ok     = f.icache_data_ok & (cancel_cnt_q == 2'd0) & ~reset;
    assign f.prefs_to_fs_valid = to_fs_valid & ~reset;
    assign f.prefs_to_fs_bus   = reset ? '0 : bus;
    assign f.dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Bench for fetch_req_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an epoch-tagged request model.
module tb_fetch_req_ctrl;
    import fetch_req_ctrl_pkg::*;

    localparam int MAX = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_req_ctrl_if ifc();

    fetch_req_ctrl #(.RESET_PC(32'hbfc00000), .MAX_OUTSTANDING(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .f     (ifc)
    );

    int total = 0;
    int bad   = 0;

    // Model: each outstanding request remembers the flush epoch it was issued in.
    logic [31:0] m_pc    = 32'hbfc00000;
    bit          m_hold  = 1'b0;
    logic [2:0]  m_held  = 3'b000;
    logic [31:0] m_epoch = 32'd0;
    logic [31:0] exp_q[$];

    logic        e_req, e_acc, e_valid, e_fdo;
    logic [31:0] e_addr;
    logic [34:0] e_bus;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_npc();
`ifdef FETCH_BPRED_EN
        if (ifc.bp_taken) return ifc.bp_target;
`endif
        return m_pc + 32'd4;
    endfunction

    function automatic void model_comb();
        logic adel, exc;
        adel    = (m_pc[1:0] != 2'b00);
        e_req   = 1'b0;
        e_acc   = 1'b0;
        e_addr  = m_pc;
        e_fdo   = ifc.icache_data_ok && (exp_q.size() > 0) && (exp_q[0] == m_epoch);
        if (!m_hold) begin
            exc     = adel | ifc.tlb_miss | ifc.tlb_invalid;
            e_req   = !exc && !ifc.redirect_valid && (exp_q.size() < MAX);
            e_acc   = (e_req && ifc.icache_addr_ok) || (exc && !ifc.redirect_valid);
            e_valid = e_acc && ifc.fs_allowin;
            e_bus   = {ifc.tlb_miss, ifc.tlb_invalid, adel, m_pc};
        end else begin
            e_valid = !ifc.redirect_valid;
            e_bus   = {m_held, m_pc};
        end
        if (reset) begin
            e_req = 1'b0; e_valid = 1'b0; e_fdo = 1'b0; e_bus = '0; e_addr = '0;
        end
    endfunction

    function automatic void model_update();
        if (reset) begin
            m_pc = 32'hbfc00000; m_hold = 1'b0; m_held = 3'b000; exp_q.delete();
            return;
        end
        if (ifc.icache_data_ok && exp_q.size() > 0) void'(exp_q.pop_front());
        if (e_req && ifc.icache_addr_ok) exp_q.push_back(m_epoch);
        if (ifc.redirect_valid) begin
            m_pc = ifc.redirect_pc; m_hold = 1'b0; m_epoch++;
        end else if (!m_hold) begin
            if (e_acc && ifc.fs_allowin) m_pc = model_npc();
            else if (e_acc) begin m_hold = 1'b1; m_held = e_bus[34:32]; end
        end else if (ifc.fs_allowin) begin
            m_pc = model_npc(); m_hold = 1'b0;
        end
    endfunction

    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic bpt, input logic [31:0] bptg, input logic miss,
                        input logic inv, input logic aok, input logic dok, input logic allow);
        @(posedge clk); #1;
        reset              = rst;
        ifc.redirect_valid = rv;
        ifc.redirect_pc    = rpc;
        ifc.bp_taken       = bpt;
        ifc.bp_target      = bptg;
        ifc.tlb_miss       = miss;
        ifc.tlb_invalid    = inv;
        ifc.icache_addr_ok = aok;
        ifc.icache_data_ok = dok && (exp_q.size() > 0) && !rst;
        ifc.fs_allowin     = allow;
        model_comb();
        @(negedge clk);
        check("icache_req", 64'(ifc.icache_req), 64'(e_req));
        check("icache_addr", 64'(ifc.icache_addr), 64'(e_addr));
        check("fs_valid", 64'(ifc.prefs_to_fs_valid), 64'(e_valid));
        check("fs_bus", 64'(ifc.prefs_to_fs_bus), 64'(e_bus));
        check("fetch_data_ok", 64'(ifc.fetch_data_ok), 64'(e_fdo));
        if (!rst) check("state", 64'(ifc.dbg_state), 64'(m_hold ? ST_HOLD : ST_REQ));
        model_update();
    endtask

    task automatic go(input logic rv, input logic [31:0] rpc, input logic aok,
                      input logic dok, input logic allow);
        step(1'b0, rv, rpc, 1'b0, 32'd0, 1'b0, 1'b0, aok, dok, allow);
    endtask

    initial begin
        ifc.redirect_valid = 0; ifc.redirect_pc = 0; ifc.bp_taken = 0; ifc.bp_target = 0;
        ifc.tlb_miss = 0; ifc.tlb_invalid = 0; ifc.icache_addr_ok = 0;
        ifc.icache_data_ok = 0; ifc.fs_allowin = 0;

        // Reset: all outputs quiet.
        step(1'b1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1'b1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("rst_req", 64'(ifc.icache_req), 64'd0);
        check("rst_valid", 64'(ifc.prefs_to_fs_valid), 64'd0);

        // Streaming from the reset PC.
        go(0, 0, 1, 0, 1);
        check("s0_req", 64'(ifc.icache_req), 64'd1);
        check("s0_addr", 64'(ifc.icache_addr), 64'hbfc00000);
        check("s0_valid", 64'(ifc.prefs_to_fs_valid), 64'd1);
        go(0, 0, 1, 1, 1);
        check("s1_addr", 64'(ifc.icache_addr), 64'hbfc00004);
        check("s1_valid", 64'(ifc.prefs_to_fs_valid), 64'd1);
        go(0, 0, 1, 1, 1);
        check("s2_addr", 64'(ifc.icache_addr), 64'hbfc00008);
        check("s2_valid", 64'(ifc.prefs_to_fs_valid), 64'd1);
        go(0, 0, 0, 1, 0);

        // HOLD while IF stalls.
        go(1, 32'hbfc00000, 0, 0, 0);
        check("rd_req", 64'(ifc.icache_req), 64'd0);
        check("rd_valid", 64'(ifc.prefs_to_fs_valid), 64'd0);
        go(0, 0, 1, 0, 0);
        check("h_acc_req", 64'(ifc.icache_req), 64'd1);
        check("h_acc_valid", 64'(ifc.prefs_to_fs_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            go(0, 0, 1, (i == 0), 0);
            check("h_req", 64'(ifc.icache_req), 64'd0);
            check("h_valid", 64'(ifc.prefs_to_fs_valid), 64'd1);
            check("h_bus", 64'(ifc.prefs_to_fs_bus), 64'h0_bfc00000);
        end
        go(0, 0, 0, 0, 1);
        check("h_release", 64'(ifc.prefs_to_fs_valid), 64'd1);
        go(0, 0, 0, 0, 0);
        check("h_next_addr", 64'(ifc.icache_addr), 64'hbfc00004);

        // Redirect with two requests in flight: two stale responses dropped.
        go(0, 0, 1, 0, 1);
        go(0, 0, 1, 0, 1);
        go(1, 32'h80000100, 0, 0, 0);
        go(0, 0, 1, 1, 0);
        check("c_full_req", 64'(ifc.icache_req), 64'd0);
        check("c_drop0", 64'(ifc.fetch_data_ok), 64'd0);
        go(0, 0, 1, 1, 1);
        check("c_new_req", 64'(ifc.icache_req), 64'd1);
        check("c_new_addr", 64'(ifc.icache_addr), 64'h80000100);
        check("c_drop1", 64'(ifc.fetch_data_ok), 64'd0);
        go(0, 0, 0, 1, 0);
        check("c_pass", 64'(ifc.fetch_data_ok), 64'd1);

        // Misaligned redirect target: handed to IF with pc_adel, no memory access.
        go(1, 32'h80000102, 0, 0, 0);
        go(0, 0, 1, 0, 1);
        check("adel_req", 64'(ifc.icache_req), 64'd0);
        check("adel_valid", 64'(ifc.prefs_to_fs_valid), 64'd1);
        check("adel_bus", 64'(ifc.prefs_to_fs_bus), 64'h1_80000102);

        // Outstanding limit.
        go(1, 32'h80000200, 0, 0, 0);
        go(0, 0, 1, 0, 1);
        go(0, 0, 1, 0, 1);
        go(0, 0, 1, 1, 1);
        check("lim_req", 64'(ifc.icache_req), 64'd0);
        go(0, 0, 1, 0, 1);
        check("lim_resume", 64'(ifc.icache_req), 64'd1);
        check("lim_addr", 64'(ifc.icache_addr), 64'h80000208);

        // Predictor at a page-crossing PC.
        go(1, 32'h80000ffc, 0, 1, 0);
        step(0, 0, 0, 1, 32'h80001000, 0, 0, 1, 1, 1);
        check("bp0_addr", 64'(ifc.icache_addr), 64'h80000ffc);
        go(0, 0, 0, 0, 0);
        check("bp0_next", 64'(ifc.icache_addr), 64'h80001000);
        go(1, 32'h80000ffc, 0, 1, 0);
        step(0, 0, 0, 1, 32'h80002000, 0, 0, 1, 0, 1);
        go(0, 0, 0, 1, 0);
`ifdef FETCH_BPRED_EN
        check("bp1_next", 64'(ifc.icache_addr), 64'h80002000);
`else
        check("bp1_next", 64'(ifc.icache_addr), 64'h80001000);
`endif
        check("bp1_data", 64'(ifc.fetch_data_ok), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rp, bt;
            rp = $urandom();
            rp[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bt = $urandom() & 32'hffff_fffc;
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 15) == 0), rp,
                 ($urandom_range(0, 3) == 0), bt,
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
